mac_tx_arbiter: RTL and testbench

MAC_TX_ARBITER -- requirements
Module: mac_tx_arbiter

---
 rtl/mac_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arbiter.sv
// Two-source round-robin transmit arbiter in front of a MAC.
// A granted source streams one frame. The first byte waits for mac_tx_ack,
// and after that one byte moves per cycle. A fixed inter-frame gap follows
// every frame, including aborted ones.
module mac_tx_arbiter #(
  parameter int IFG_CYCLES  = 12,
  parameter int MAX_LEN     = 1518,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        tx_enable,
  input  logic        s0_req,
  input  logic        s1_req,
  input  logic [7:0]  s0_data,
  input  logic [7:0]  s1_data,
  input  logic        s0_last,
  input  logic        s1_last,
  output logic        s0_gnt,
  output logic        s1_gnt,
  output logic        s0_rd,
  output logic        s1_rd,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack,
  output logic        conf_tx_en,
  output logic        conf_tx_jumbo_en,
  output logic        conf_tx_no_gen_crc,
  output logic        err_oversize,
  output logic        err_ack_timeout,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [10:0]      MAX_LEN_C  = 11'(MAX_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, XFER, GAP} state_t;

  state_t           state;
  logic             gnt_sel;      // 0: s0 owns the port, 1: s1 owns it
  logic             last_served;
  logic [10:0]      byte_cnt;     // bytes of the current frame already consumed
  logic [TMR_W-1:0] ack_tmr;
  logic [GAP_W-1:0] gap_cnt;

  logic active;
  logic sel_last;
  logic oversize;
  logic consume;
  logic winner;

  assign active   = (state == WAIT_ACK) || (state == XFER);
  assign sel_last = gnt_sel ? s1_last : s0_last;
  // The byte after MAX_LEN consumed bytes is not taken. The frame is cut instead.
  assign oversize = (state == XFER) && !sel_last && (byte_cnt == MAX_LEN_C);
  assign consume  = ((state == WAIT_ACK) && mac_tx_ack) || ((state == XFER) && !oversize);

  assign s0_gnt      = active && !gnt_sel;
  assign s1_gnt      = active && gnt_sel;
  assign s0_rd       = consume && !gnt_sel;
  assign s1_rd       = consume && gnt_sel;
  assign mac_tx_dvld = active;
  assign mac_tx_data = active ? (gnt_sel ? s1_data : s0_data) : 8'd0;
  assign frame_done  = consume && sel_last;

  assign conf_tx_jumbo_en   = 1'b0;
  assign conf_tx_no_gen_crc = 1'b0;

  // Round-robin pick: on contention, serve the source that did not go last.
  always_comb begin
    winner = 1'b0;
    if (s0_req && s1_req) winner = ~last_served;
    else                  winner = s1_req;
  end

  // Configuration mirror of the enable input, one cycle late.
  always_ff @(posedge tx_clk) begin
    if (reset) conf_tx_en <= 1'b0;
    else       conf_tx_en <= tx_enable;
  end

  // Frame sequencing: grant, first-byte handshake, streaming, aborts and gap.
  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state           <= IDLE;
      gnt_sel         <= 1'b0;
      last_served     <= 1'b1;
      byte_cnt        <= 11'd0;
      ack_tmr         <= '0;
      gap_cnt         <= '0;
      err_oversize    <= 1'b0;
      err_ack_timeout <= 1'b0;
      frame_cnt       <= 16'd0;
    end else begin
      err_oversize    <= 1'b0;
      err_ack_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_enable && (s0_req || s1_req)) begin
            gnt_sel     <= winner;
            last_served <= winner;
            byte_cnt    <= 11'd0;
            ack_tmr     <= '0;
            state       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (mac_tx_ack) begin
            byte_cnt <= 11'd1;
            if (sel_last) begin
              frame_cnt <= frame_cnt + 16'd1;
              gap_cnt   <= '0;
              state     <= GAP;
            end else begin
              state <= XFER;
            end
          end else if (ack_tmr == TMR_LAST) begin
            err_ack_timeout <= 1'b1;
            gap_cnt         <= '0;
            state           <= GAP;
          end else begin
            ack_tmr <= ack_tmr + 1'b1;
          end
        end
        XFER: begin
          if (oversize) begin
            err_oversize <= 1'b1;
            gap_cnt      <= '0;
            state        <= GAP;
          end else begin
            byte_cnt <= byte_cnt + 11'd1;
            if (sel_last) begin
              frame_cnt <= frame_cnt + 16'd1;
              gap_cnt   <= '0;
              state     <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Scoreboard bench for mac_tx_arbiter: behavioural sources and MAC ack model,
// expected byte stream queued in grant order when frames are offered.
module tb_mac_tx_arbiter;

  localparam int IFG   = 12;
  localparam int MAXL  = 1518;
  localparam int ACKTO = 1024;

  logic        tx_clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_enable = 1'b0;
  logic        s0_req = 1'b0, s1_req = 1'b0;
  logic [7:0]  s0_data = 8'd0, s1_data = 8'd0;
  logic        s0_last = 1'b0, s1_last = 1'b0;
  logic        s0_gnt, s1_gnt, s0_rd, s1_rd;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_dvld;
  logic        mac_tx_ack = 1'b0;
  logic        conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc;
  logic        err_oversize, err_ack_timeout, frame_done;
  logic [15:0] frame_cnt;

  always #5 tx_clk = ~tx_clk;

  mac_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_LEN(MAXL), .ACK_TIMEOUT(ACKTO)) dut (
    .tx_clk(tx_clk), .reset(reset), .tx_enable(tx_enable),
    .s0_req(s0_req), .s1_req(s1_req), .s0_data(s0_data), .s1_data(s1_data),
    .s0_last(s0_last), .s1_last(s1_last), .s0_gnt(s0_gnt), .s1_gnt(s1_gnt),
    .s0_rd(s0_rd), .s1_rd(s1_rd), .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld),
    .mac_tx_ack(mac_tx_ack), .conf_tx_en(conf_tx_en), .conf_tx_jumbo_en(conf_tx_jumbo_en),
    .conf_tx_no_gen_crc(conf_tx_no_gen_crc), .err_oversize(err_oversize),
    .err_ack_timeout(err_ack_timeout), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  // len 0 means the source never raises last; ack -1 means the MAC never acks.
  typedef struct {int len; int ack; int fid;} frame_t;

  frame_t     fq0[$], fq1[$];
  logic [9:0] sb[$];          // {frame_done expected, source, byte}
  int         runs[$];        // dvld-high run lengths
  int         n_cmp = 0, n_bad = 0;
  int         idx[2] = '{0, 0};
  int         fid_ctr[2] = '{0, 0};
  int         act = -1, wcnt = 0;
  bit         noise = 0;
  int         n_done = 0, n_err_ov = 0, n_err_to = 0, n_starts = 0, n_rd = 0;
  int         dvld_run = 0, idle_run = 0;
  bit         first = 1;
  logic       rd0, rd1, lst0, lst1, err_s, rst_s;
  logic [9:0] e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int s, input int f, input int i);
    return 8'(s * 97 + f * 31 + i * 7 + 5);
  endfunction

  task automatic send(input int s, input int len, input int ack, input int nexp);
    frame_t fr;
    fr.len = len; fr.ack = ack; fr.fid = fid_ctr[s];
    fid_ctr[s]++;
    for (int i = 0; i < nexp; i++)
      sb.push_back({(len > 0 && i == len - 1) ? 1'b1 : 1'b0, (s == 1) ? 1'b1 : 1'b0,
                    byte_of(s, fr.fid, i)});
    if (s == 0) fq0.push_back(fr);
    else        fq1.push_back(fr);
  endtask

  task automatic drive_sources();
    if (fq0.size() > 0) begin
      s0_req = 1'b1; s0_data = byte_of(0, fq0[0].fid, idx[0]);
      s0_last = (fq0[0].len > 0) && (idx[0] == fq0[0].len - 1);
    end else begin
      s0_req = 1'b0; s0_data = 8'd0; s0_last = 1'b0;
    end
    if (fq1.size() > 0) begin
      s1_req = 1'b1; s1_data = byte_of(1, fq1[0].fid, idx[1]);
      s1_last = (fq1[0].len > 0) && (idx[1] == fq1[0].len - 1);
    end else begin
      s1_req = 1'b0; s1_data = 8'd0; s1_last = 1'b0;
    end
  endtask

  // Monitor at negedge, source/MAC model update just after posedge.
  initial begin
    int d;
    forever begin
      @(negedge tx_clk);
      rd0 = s0_rd; rd1 = s1_rd; lst0 = s0_last; lst1 = s1_last;
      err_s = err_oversize | err_ack_timeout; rst_s = reset;
      check("gnt_onehot", s0_gnt & s1_gnt, 0);
      if (rd0 || rd1) begin
        n_rd++;
        if (rd0 && rd1) check("rd_onehot", 1, 0);
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          check("byte", {rd1, mac_tx_data}, e[8:0]);
          check("done_align", frame_done, e[9]);
        end
      end else if (frame_done) check("done_without_rd", 1, 0);
      if (frame_done)      n_done++;
      if (err_oversize)    n_err_ov++;
      if (err_ack_timeout) n_err_to++;
      if (mac_tx_dvld) begin
        if (dvld_run == 0) begin
          n_starts++;
          if (!first) check("ifg", idle_run >= IFG, 1);
          first = 0;
        end
        dvld_run++; idle_run = 0;
      end else begin
        if (dvld_run > 0) runs.push_back(dvld_run);
        dvld_run = 0; idle_run++;
      end
      if (reset) first = 1;

      @(posedge tx_clk); #1;
      if (rst_s) begin
        fq0.delete(); fq1.delete(); idx = '{0, 0}; act = -1;
      end else begin
        if (rd0) begin
          if (lst0) begin fq0.delete(0); idx[0] = 0; end else idx[0]++;
        end
        if (rd1) begin
          if (lst1) begin fq1.delete(0); idx[1] = 0; end else idx[1]++;
        end
        if (err_s && act == 0 && fq0.size() > 0) begin fq0.delete(0); idx[0] = 0; end
        if (err_s && act == 1 && fq1.size() > 0) begin fq1.delete(0); idx[1] = 0; end
      end
      if (s0_gnt) act = 0;
      else if (s1_gnt) act = 1;
      drive_sources();
      if (mac_tx_dvld && act >= 0) begin
        d = -1;
        if (act == 0 && fq0.size() > 0) d = fq0[0].ack;
        if (act == 1 && fq1.size() > 0) d = fq1[0].ack;
        if (d >= 0 && wcnt == d)              mac_tx_ack = 1'b1;
        else if (d >= 0 && wcnt > d && noise) mac_tx_ack = 1'($urandom_range(0, 1));
        else                                  mac_tx_ack = 1'b0;
        wcnt++;
      end else begin
        wcnt = 0; mac_tx_ack = 1'b0;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(fq0.size() == 0 && fq1.size() == 0 && sb.size() == 0 && !mac_tx_dvld) && n < budget) begin
      @(posedge tx_clk); #2;
      n++;
    end
    if (n >= budget) check("drain_timeout", 1, 0);
    repeat (IFG + 2) @(posedge tx_clk);
    #2;
  endtask

  initial begin
    int s_base, d_base, n;
    // Reset state
    reset = 1'b1; tx_enable = 1'b1;
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    check("reset_outs", {s0_gnt, s1_gnt, s0_rd, s1_rd, mac_tx_dvld, conf_tx_en, conf_tx_jumbo_en,
                         conf_tx_no_gen_crc, err_oversize, err_ack_timeout, frame_done}, 0);
    check("reset_data", mac_tx_data, 0);
    check("reset_cnt", frame_cnt, 0);
    @(posedge tx_clk); #2 reset = 1'b0;
    @(posedge tx_clk); #2;
    check("conf_tx_en_on", conf_tx_en, 1);

    // 60-byte frame from s0, ack three cycles after dvld
    runs.delete(); n_rd = 0;
    send(0, 60, 3, 60);
    wait_idle(400);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_done", n_done, 1);
    check("t1_rd", n_rd, 60);
    check("t1_run", runs.size() > 0 ? runs[0] : -1, 63);

    // Both sources busy: s1 first (s0 went last), then alternating
    noise = 1; s_base = n_starts;
    for (int k = 0; k < 4; k++) begin
      send(1, 3 + 2 * k, 0, 3 + 2 * k);
      send(0, 5 + k, 1, 5 + k);
    end
    wait_idle(2000);
    noise = 0;
    check("t2_frame_cnt", frame_cnt, 9);
    check("t2_starts", n_starts - s_base, 8);

    // Ack timeout on s1, then s0 is served
    runs.delete();
    send(1, 10, -1, 0);
    send(0, 8, 2, 8);
    wait_idle(3000);
    check("t3_err_to", n_err_to, 1);
    check("t3_run", runs.size() > 0 ? runs[0] : -1, ACKTO);
    check("t3_frame_cnt", frame_cnt, 10);

    // Source never asserts last
    runs.delete(); n_rd = 0;
    send(0, 0, 0, MAXL);
    wait_idle(4000);
    check("t4_err_ov", n_err_ov, 1);
    check("t4_rd", n_rd, MAXL);
    check("t4_run", runs.size() > 0 ? runs[0] : -1, MAXL + 1);
    check("t4_frame_cnt", frame_cnt, 10);

    // One-byte frame
    runs.delete(); n_rd = 0; d_base = n_done;
    send(1, 1, 2, 1);
    wait_idle(200);
    check("t5_rd", n_rd, 1);
    check("t5_done", n_done - d_base, 1);
    check("t5_run", runs.size() > 0 ? runs[0] : -1, 3);
    check("t5_frame_cnt", frame_cnt, 11);

    // tx_enable blocks grants but never truncates a running frame
    tx_enable = 1'b0; s_base = n_starts;
    send(0, 30, 1, 30);
    repeat (20) @(posedge tx_clk);
    #2;
    check("t7_blocked", n_starts - s_base, 0);
    check("t7_conf_off", conf_tx_en, 0);
    tx_enable = 1'b1;
    n = 0;
    while (!mac_tx_dvld && n < 50) begin @(posedge tx_clk); #2; n++; end
    if (n >= 50) check("t7_grant_timeout", 1, 0);
    repeat (5) @(posedge tx_clk);
    #2 tx_enable = 1'b0;
    wait_idle(500);
    check("t7_frame_cnt", frame_cnt, 12);
    tx_enable = 1'b1;

    // Reset on byte 20 of a frame, then both sources: s0 first
    send(0, 60, 1, 20);
    n = 0;
    while (!(fq0.size() > 0 && idx[0] == 19) && n < 200) begin @(posedge tx_clk); #2; n++; end
    if (n >= 200) check("t6_byte20_timeout", 1, 0);
    reset = 1'b1;
    @(posedge tx_clk); #2 reset = 1'b0;
    @(negedge tx_clk);
    check("t6_reset_outs", {s0_gnt, s1_gnt, s0_rd, s1_rd, mac_tx_dvld, conf_tx_en,
                            err_oversize, err_ack_timeout, frame_done}, 0);
    check("t6_reset_cnt", frame_cnt, 0);
    check("t6_sb_flushed", sb.size(), 0);
    @(posedge tx_clk); #2;
    send(0, 5, 0, 5);
    send(1, 6, 1, 6);
    wait_idle(300);
    check("t6_frame_cnt", frame_cnt, 2);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
